exec_sequencer: RTL and testbench

Issue-side controller for the execution stage, sitting beside the result multiplexer and the Hi/Lo multiply unit. It accepts one funct code per cycle and classifies it. It then drives the result select, sequences the multi-cycle MULTU iteration, and writes Hi/Lo. MFHI, MFLO and a second MULTU stall while a multiply is in flight. ALU and SRL ops keep flowing during a multiply.

---
 rtl/exec_defs.sv | 63 ++++++
 rtl/mul_iter_counter.sv | 44 ++++
 rtl/exec_sequencer.sv | 134 +++++++++++++
 tb/tb_exec_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/exec_defs.sv
// -----------------------------------------------------------------------------
// exec_defs
// Shared definitions for the execution-stage issue controller and the result
// multiplexer: funct codes, result-mux select encodings, sequencer states,
// op classes and the decode helpers both consumers rely on.
// -----------------------------------------------------------------------------
package exec_defs;

  // Funct codes recognised by the execution stage.
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;

  // Result multiplexer select encodings.
  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_HI  = 2'd1;
  localparam logic [1:0] SEL_LO  = 2'd2;
  localparam logic [1:0] SEL_SH  = 2'd3;

  // Multiply sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MUL  = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Op classes derived from the funct code.
  typedef enum logic [2:0] {
    CLS_ALU = 3'd0,
    CLS_SH  = 3'd1,
    CLS_HL  = 3'd2,
    CLS_MUL = 3'd3,
    CLS_ILL = 3'd4
  } op_class_e;

  function automatic op_class_e classify(input logic [5:0] funct);
    case (funct)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT: return CLS_ALU;
      F_SRL:                            return CLS_SH;
      F_MFHI, F_MFLO:                   return CLS_HL;
      F_MULTU:                          return CLS_MUL;
      default:                          return CLS_ILL;
    endcase
  endfunction

  // Result-mux source for ops that produce a result; ALU is the fallback.
  function automatic logic [1:0] result_sel(input logic [5:0] funct);
    case (funct)
      F_MFHI:  return SEL_HI;
      F_MFLO:  return SEL_LO;
      F_SRL:   return SEL_SH;
      default: return SEL_ALU;
    endcase
  endfunction

endpackage

// File: rtl/mul_iter_counter.sv
// -----------------------------------------------------------------------------
// mul_iter_counter
// Loadable down-counter that paces the MULTU shift-add iterations.
// Ports:
//   clk      - clock
//   reset    - synchronous, active-high
//   clear_i  - force the count to zero (sequencer idle)
//   load_i   - load MUL_CYCLES
//   dec_i    - decrement by one; saturates at zero, never wraps
//   last_o   - count equals one: the current iteration is the final one
// -----------------------------------------------------------------------------
module mul_iter_counter #(
  parameter int MUL_CYCLES = 32,
  parameter int CNT_W      = $clog2(MUL_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic load_i,
  input  logic dec_i,
  output logic last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks assign a default first so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                      cnt_d = '0;
    else if (load_i)                  cnt_d = CNT_W'(MUL_CYCLES);
    else if (dec_i && cnt_q != '0)    cnt_d = cnt_q - CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/exec_sequencer.sv
// -----------------------------------------------------------------------------
// exec_sequencer
// Issue-side controller for the execution stage. Classifies one funct code per
// cycle, drives the result-mux select, sequences the multi-cycle MULTU and
// commits Hi/Lo. MFHI/MFLO and a second MULTU stall while a multiply is in
// flight; ALU and SRL ops keep flowing.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   issue_valid  - Signal carries an op this cycle
//   Signal       - 6-bit funct code
//   issue_ready  - combinational; op accepted when issue_valid & issue_ready
//   res_sel      - registered result-mux select (ALU/Hi/Lo/Shifter)
//   res_valid    - registered; result data meaningful this cycle
//   mul_load     - registered pulse: load operands, clear product
//   mul_step     - registered; one shift-add iteration
//   hilo_we      - registered pulse: commit product to Hi/Lo
//   busy         - registered; a MULTU is in flight
//   illegal      - registered pulse for an unrecognised funct code
// -----------------------------------------------------------------------------
module exec_sequencer
  import exec_defs::*;
#(
  parameter int MUL_CYCLES = 32,
  parameter int CNT_W      = $clog2(MUL_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid,
  input  logic [5:0] Signal,
  output logic       issue_ready,
  output logic [1:0] res_sel,
  output logic       res_valid,
  output logic       mul_load,
  output logic       mul_step,
  output logic       hilo_we,
  output logic       busy,
  output logic       illegal
);

  state_e     state_q, state_d;
  op_class_e  op_cls;
  logic       accept;
  logic       cnt_last;

  logic [1:0] res_sel_q,   res_sel_d;
  logic       res_valid_q, res_valid_d;
  logic       mul_load_q,  mul_load_d;
  logic       mul_step_q,  mul_step_d;
  logic       hilo_we_q,   hilo_we_d;
  logic       busy_q,      busy_d;
  logic       illegal_q,   illegal_d;

  assign op_cls = classify(Signal);

  // Only Hi/Lo reads and a new multiply depend on the sequencer being idle.
  always_comb begin
    issue_ready = 1'b0;
    if (!reset)
      issue_ready = (state_q == ST_IDLE) || (op_cls != CLS_HL && op_cls != CLS_MUL);
  end

  assign accept = issue_valid & issue_ready;

  mul_iter_counter #(
    .MUL_CYCLES (MUL_CYCLES),
    .CNT_W      (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear_i (state_q == ST_IDLE),
    .load_i  (state_q == ST_LOAD),
    .dec_i   (state_q == ST_MUL),
    .last_o  (cnt_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && op_cls == CLS_MUL) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_MUL;
      ST_MUL:  if (cnt_last) state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic. Multiply controls are decoded from the next state so the
  // registered copies line up with the state they describe.
  always_comb begin
    mul_load_d  = (state_d == ST_LOAD);
    mul_step_d  = (state_d == ST_MUL);
    hilo_we_d   = (state_d == ST_WB);
    busy_d      = (state_d != ST_IDLE);
    res_valid_d = accept && (op_cls == CLS_ALU || op_cls == CLS_SH || op_cls == CLS_HL);
    illegal_d   = accept && (op_cls == CLS_ILL);
    res_sel_d   = res_valid_d ? result_sel(Signal) : res_sel_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_sel_q   <= SEL_ALU;
      res_valid_q <= 1'b0;
      mul_load_q  <= 1'b0;
      mul_step_q  <= 1'b0;
      hilo_we_q   <= 1'b0;
      busy_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      res_sel_q   <= res_sel_d;
      res_valid_q <= res_valid_d;
      mul_load_q  <= mul_load_d;
      mul_step_q  <= mul_step_d;
      hilo_we_q   <= hilo_we_d;
      busy_q      <= busy_d;
      illegal_q   <= illegal_d;
    end
  end

  assign res_sel   = res_sel_q;
  assign res_valid = res_valid_q;
  assign mul_load  = mul_load_q;
  assign mul_step  = mul_step_q;
  assign hilo_we   = hilo_we_q;
  assign busy      = busy_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exec_sequencer
// Directed stimulus with hand-computed expectations. The driver pushes the
// expected result events and multiply start cycles into queues; a monitor on
// the falling edge compares every cycle.
// Cycle n is the interval after the n-th rising edge (cycle 0 precedes the
// first edge). Inputs change 1 time unit after a rising edge.
// -----------------------------------------------------------------------------
module tb_exec_sequencer;
  import exec_defs::*;

  localparam int M = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic [5:0] Signal;
  logic       issue_ready;
  logic [1:0] res_sel;
  logic       res_valid, mul_load, mul_step, hilo_we, busy, illegal;

  exec_sequencer #(.MUL_CYCLES(M)) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .Signal      (Signal),
    .issue_ready (issue_ready),
    .res_sel     (res_sel),
    .res_valid   (res_valid),
    .mul_load    (mul_load),
    .mul_step    (mul_step),
    .hilo_we     (hilo_we),
    .busy        (busy),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  bit rst_at_edge = 1'b0;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= reset;
  end

  typedef struct {int cyc; logic [1:0] sel; bit ill;} res_exp_t;
  typedef struct {int t; int cut;} mul_rec_t;

  res_exp_t sb[$];
  mul_rec_t mq[$];

  int         checks   = 0;
  int         failures = 0;
  logic [1:0] last_sel = SEL_ALU;
  bit         done     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit stalls(input logic [5:0] f);
    return (f == F_MFHI) || (f == F_MFLO) || (f == F_MULTU);
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    bit e_load, e_step, e_we, e_busy;
    res_exp_t e;
    if (cyc >= 3 && !done) begin
      e_load = 1'b0; e_step = 1'b0; e_we = 1'b0; e_busy = 1'b0;
      foreach (mq[i]) begin
        if (cyc <= mq[i].cut) begin
          if (cyc == mq[i].t + 1) e_load = 1'b1;
          if (cyc >= mq[i].t + 2 && cyc <= mq[i].t + 1 + M) e_step = 1'b1;
          if (cyc == mq[i].t + 2 + M) e_we = 1'b1;
          if (cyc >= mq[i].t + 1 && cyc <= mq[i].t + 2 + M) e_busy = 1'b1;
        end
      end
      check("mul_load", 32'(mul_load), 32'(e_load));
      check("mul_step", 32'(mul_step), 32'(e_step));
      check("hilo_we",  32'(hilo_we),  32'(e_we));
      check("busy",     32'(busy),     32'(e_busy));
      check("issue_ready", 32'(issue_ready),
            32'(!reset && (!e_busy || !stalls(Signal))));

      if (rst_at_edge) last_sel = SEL_ALU;
      if (res_valid || illegal) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          check("result_cycle", 32'(cyc), 32'(e.cyc));
          check("illegal", 32'(illegal), 32'(e.ill));
          check("res_valid", 32'(res_valid), 32'(!e.ill));
          if (!e.ill) last_sel = e.sel;
        end
      end
      check("res_sel", 32'(res_sel), 32'(last_sel));
    end
  end

  task automatic wait_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive an op in cycle c. acc: expected to be accepted this cycle.
  task automatic drive(input int c, input logic [5:0] f, input bit acc,
                       input bit ill, input logic [1:0] sel);
    res_exp_t e;
    mul_rec_t r;
    wait_cycle(c);
    issue_valid = 1'b1;
    Signal      = f;
    if (acc) begin
      if (f == F_MULTU) begin
        r.t = c; r.cut = 1 << 30;
        mq.push_back(r);
      end else begin
        e.cyc = c + 1; e.sel = sel; e.ill = ill;
        sb.push_back(e);
      end
    end
  endtask

  task automatic quiet(input int c);
    wait_cycle(c);
    issue_valid = 1'b0;
    Signal      = 6'($urandom);
  endtask

  initial begin
    reset = 1'b1; issue_valid = 1'b0; Signal = 6'b0;
    wait_cycle(3);
    reset = 1'b0;

    drive(5, F_ADD, 1, 0, SEL_ALU);  quiet(6);
    drive(7, F_OR,  1, 0, SEL_ALU);  quiet(8);

    // Multiply 1: load 11, steps 12..43, commit 44, idle 45.
    drive(10, F_MULTU, 1, 0, SEL_ALU); quiet(11);
    for (int c = 12; c <= 19; c++) drive(c, F_MFLO, 0, 0, SEL_ALU);
    drive(20, F_SRL, 1, 0, SEL_SH);
    drive(21, F_SUB, 1, 0, SEL_ALU);
    drive(22, F_SLT, 1, 0, SEL_ALU);
    for (int c = 23; c <= 44; c++) drive(c, F_MFLO, 0, 0, SEL_ALU);
    drive(45, F_MFLO,    1, 0, SEL_LO);
    drive(46, F_MFHI,    1, 0, SEL_HI);
    drive(47, 6'b111111, 1, 1, SEL_ALU);  quiet(48);
    drive(50, F_ADD,     1, 0, SEL_ALU);  quiet(51);
    drive(53, 6'b000000, 1, 1, SEL_ALU);  quiet(54);

    // Multiply 2: commit at 94, ALU op in the same WB cycle.
    drive(60, F_MULTU, 1, 0, SEL_ALU); quiet(61);
    drive(70, F_MULTU, 0, 0, SEL_ALU);
    drive(71, F_MFHI,  0, 0, SEL_ALU); quiet(72);
    drive(93, F_SRL,  1, 0, SEL_SH);
    drive(94, F_AND,  1, 0, SEL_ALU);
    drive(95, F_MFHI, 1, 0, SEL_HI);   quiet(96);

    // Multiply 3 aborted by reset in cycle 110, then a fresh MULTU.
    drive(100, F_MULTU, 1, 0, SEL_ALU); quiet(101);
    wait_cycle(110);
    reset = 1'b1; issue_valid = 1'b1; Signal = F_ADD;
    mq[mq.size()-1].cut = 110;
    wait_cycle(111);
    reset = 1'b0; issue_valid = 1'b0;
    drive(112, F_MULTU, 1, 0, SEL_ALU); quiet(113);

    wait_cycle(150);
    done = 1'b1;
    check("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
